// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared opcodes, bus widths and state encoding for div_ctrl
// Contents: INST_* funct3 codes, RegBus/RegAddrBus widths, one-hot controller states.
package div_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_RUN   = 4'b0010,
    S_WB    = 4'b0100,
    S_ABORT = 4'b1000
  } div_state_e;

endpackage

// File: rtl/div_result_cache.sv
// rtl/div_result_cache.sv - one-entry result cache keyed on (op, dividend, divisor)
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   lookup_op/dividend/divisor  key to compare against the stored entry
//   hit, hit_data               combinational match flag and stored result
//   wr_en, wr_op/dividend/divisor/data  overwrite the entry and mark it valid
module div_result_cache
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        lookup_op,
  input  logic [RegBus-1:0] lookup_dividend,
  input  logic [RegBus-1:0] lookup_divisor,
  output logic              hit,
  output logic [RegBus-1:0] hit_data,
  input  logic              wr_en,
  input  logic [2:0]        wr_op,
  input  logic [RegBus-1:0] wr_dividend,
  input  logic [RegBus-1:0] wr_divisor,
  input  logic [RegBus-1:0] wr_data
);

  logic              valid_q;
  logic [2:0]        op_q;
  logic [RegBus-1:0] dividend_q;
  logic [RegBus-1:0] divisor_q;
  logic [RegBus-1:0] data_q;

  // Only reset clears the entry: a quotient/remainder never goes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      data_q     <= '0;
    end else if (wr_en) begin
      valid_q    <= 1'b1;
      op_q       <= wr_op;
      dividend_q <= wr_dividend;
      divisor_q  <= wr_divisor;
      data_q     <= wr_data;
    end
  end

  // The opcode is part of the key so DIV and REM of the same operands differ.
  assign hit = valid_q && (lookup_op == op_q) &&
               (lookup_dividend == dividend_q) && (lookup_divisor == divisor_q);
  assign hit_data = data_q;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing controller between execute stage and iterative divider
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_*                          div-class request from execute (held while hold_o=1)
//   flush_i                        pipeline flush, kills the in-flight request
//   hold_o                         pipeline stall request
//   wb_valid_o/wb_waddr_o/wb_data_o  registered one-cycle write-back
//   div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o  divider command
//   div_ready_i, div_result_i, div_busy_i  divider response / status
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic [2:0]            req_op_i,
  input  logic [RegBus-1:0]     req_dividend_i,
  input  logic [RegBus-1:0]     req_divisor_i,
  input  logic [RegAddrBus-1:0] req_waddr_i,
  input  logic                  flush_i,
  output logic                  hold_o,
  output logic                  wb_valid_o,
  output logic [RegAddrBus-1:0] wb_waddr_o,
  output logic [RegBus-1:0]     wb_data_o,
  output logic                  div_start_o,
  output logic [2:0]            div_op_o,
  output logic [RegBus-1:0]     div_dividend_o,
  output logic [RegBus-1:0]     div_divisor_o,
  output logic [RegAddrBus-1:0] div_waddr_o,
  input  logic                  div_ready_i,
  input  logic [RegBus-1:0]     div_result_i,
  input  logic                  div_busy_i
);

  div_state_e state_q, state_d;

  logic [2:0]            op_q;
  logic [RegBus-1:0]     dividend_q;
  logic [RegBus-1:0]     divisor_q;
  logic [RegAddrBus-1:0] waddr_q;

  logic                  wb_valid_q;
  logic [RegAddrBus-1:0] wb_waddr_q;
  logic [RegBus-1:0]     wb_data_q;

  logic              accept;
  logic              run_done;
  logic              cache_hit;
  logic [RegBus-1:0] cache_data;

  assign accept   = (state_q == S_IDLE) && req_valid_i && !flush_i;
  // A flush coinciding with ready wins: the result is dropped and not cached.
  assign run_done = (state_q == S_RUN) && div_ready_i && !flush_i;

  if (CACHE_EN) begin : g_cache
    div_result_cache u_cache (
      .clk             (clk),
      .rst             (rst),
      .lookup_op       (req_op_i),
      .lookup_dividend (req_dividend_i),
      .lookup_divisor  (req_divisor_i),
      .hit             (cache_hit),
      .hit_data        (cache_data),
      .wr_en           (run_done),
      .wr_op           (op_q),
      .wr_dividend     (dividend_q),
      .wr_divisor      (divisor_q),
      .wr_data         (div_result_i)
    );
  end else begin : g_no_cache
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
  end

  always_comb begin
    state_d     = state_q;
    hold_o      = 1'b0;
    div_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hold_o  = 1'b1;
          state_d = cache_hit ? S_WB : S_RUN;
        end
      end
      S_RUN: begin
        hold_o = 1'b1;
        // Dropping start in the ready cycle keeps the divider from relaunching.
        div_start_o = !div_ready_i && !flush_i;
        if (flush_i) begin
          state_d = S_ABORT;
        end else if (div_ready_i) begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      waddr_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_data_q  <= '0;
      if (accept) begin
        op_q       <= req_op_i;
        dividend_q <= req_dividend_i;
        divisor_q  <= req_divisor_i;
        waddr_q    <= req_waddr_i;
        if (cache_hit) begin
          wb_valid_q <= 1'b1;
          wb_waddr_q <= req_waddr_i;
          wb_data_q  <= cache_data;
        end
      end
      if (run_done) begin
        wb_valid_q <= 1'b1;
        wb_waddr_q <= waddr_q;
        wb_data_q  <= div_result_i;
      end
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_data_o      = wb_data_q;
  assign div_op_o       = op_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_waddr_o    = waddr_q;

  a_start_only_in_run: assert property (@(posedge clk) disable iff (rst)
    div_start_o |-> (state_q == S_RUN));
  a_wb_single_cycle: assert property (@(posedge clk) disable iff (rst)
    wb_valid_o |=> !wb_valid_o);
  a_result_taken_in_run_only: assert property (@(posedge clk) disable iff (rst)
    run_done |-> (state_q == S_RUN));
  a_divider_idle_when_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_IDLE) |-> !div_busy_i);

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized self-checking bench for div_ctrl with divider and cache model
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam bit CACHE_EN = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_dividend_i, req_divisor_i;
  logic [4:0]  req_waddr_i;
  logic        flush_i;
  logic        hold_o, wb_valid_o, div_start_o;
  logic [4:0]  wb_waddr_o, div_waddr_o;
  logic [31:0] wb_data_o, div_dividend_o, div_divisor_o;
  logic [2:0]  div_op_o;
  logic        div_ready_i, div_busy_i;
  logic [31:0] div_result_i;

  always #5 clk = ~clk;

  div_ctrl #(.CACHE_EN(CACHE_EN)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .req_waddr_i(req_waddr_i), .flush_i(flush_i), .hold_o(hold_o),
    .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o), .wb_data_o(wb_data_o),
    .div_start_o(div_start_o), .div_op_o(div_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_waddr_o(div_waddr_o), .div_ready_i(div_ready_i),
    .div_result_i(div_result_i), .div_busy_i(div_busy_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics, computed in 64-bit so INT_MIN/-1 cannot trap.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INST_REM:  return (b == 0) ? a : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider model: zero divisor answers one cycle after start, else 31..34 cycles;
  // dropping start aborts. Result bus carries noise outside the ready pulse.
  logic        dv_running;
  int          dv_cnt;
  logic [31:0] dv_res;
  assign div_busy_i = dv_running;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_running   <= 1'b0;
      dv_cnt       <= 0;
      dv_res       <= '0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
    end else begin
      div_ready_i  <= 1'b0;
      div_result_i <= $urandom;
      if (!dv_running) begin
        if (div_start_o) begin
          if (div_divisor_o == 0) begin
            div_ready_i  <= 1'b1;
            div_result_i <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
          end else begin
            dv_running <= 1'b1;
            dv_cnt     <= $urandom_range(30, 33);
            dv_res     <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
          end
        end
      end else if (!div_start_o) begin
        dv_running <= 1'b0;
      end else if (dv_cnt == 0) begin
        div_ready_i  <= 1'b1;
        div_result_i <= dv_res;
        dv_running   <= 1'b0;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  typedef struct {logic [4:0] waddr; logic [31:0] data;} wb_t;
  wb_t exp_q[$];

  // Per-cycle compare: every write-back must match the oldest expected one.
  logic        prev_wb = 1'b0, prev_start = 1'b0, prev_ready = 1'b0;
  logic [2:0]  prev_op = '0;
  logic [31:0] prev_a = '0, prev_b = '0;
  always @(negedge clk) begin
    wb_t e;
    if (!rst) begin
      check("wb_back_to_back", prev_wb && wb_valid_o, 1'b0);
      check("start_during_ready", div_start_o && div_ready_i, 1'b0);
      check("start_during_flush", div_start_o && flush_i, 1'b0);
      check("restart_after_ready", prev_ready && div_start_o, 1'b0);
      if (prev_start && div_start_o)
        check("operands_stable", {div_op_o, div_dividend_o, div_divisor_o} ==
                                 {prev_op, prev_a, prev_b}, 1'b1);
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", wb_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wb_data", wb_data_o, e.data);
          check("wb_waddr", wb_waddr_o, e.waddr);
        end
      end
    end
    prev_wb    = wb_valid_o;
    prev_start = div_start_o;
    prev_ready = div_ready_i;
    prev_op    = div_op_o;
    prev_a     = div_dividend_o;
    prev_b     = div_divisor_o;
  end

  logic        mc_valid = 1'b0;
  logic [2:0]  mc_op = '0;
  logic [31:0] mc_a = '0, mc_b = '0, mc_res = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_tail();
    check("abort_no_wb", wb_valid_o, 1'b0);
    check("abort_hold", hold_o, 1'b0);
    check("abort_no_start", div_start_o, 1'b0);
    step();
    req_valid_i = 1'b0;
    #1;
    check("after_abort_idle_hold", hold_o, 1'b0);
    check("after_abort_idle_start", div_start_o, 1'b0);
    check("after_abort_no_wb", wb_valid_o, 1'b0);
  endtask

  // mode: 0 plain, 1 flush after flush_at RUN cycles, 2 flush with ready, 3 flush in WB
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input int mode, input int flush_at);
    logic [31:0] exp_v;
    bit hit, done;
    int run_cycles;
    exp_v = ref_div(op, a, b);
    hit = CACHE_EN && mc_valid && mc_op == op && mc_a == a && mc_b == b;
    req_valid_i = 1'b1; req_op_i = op; req_dividend_i = a; req_divisor_i = b;
    req_waddr_i = wa; flush_i = 1'b0;
    #1;
    check("hold_on_request", hold_o, 1'b1);
    if (hit) begin
      exp_q.push_back('{waddr: wa, data: mc_res});
      step();
      check("hit_wb_latency", wb_valid_o, 1'b1);
      check("hit_no_start", div_start_o, 1'b0);
      check("hit_wb_hold", hold_o, 1'b0);
      req_valid_i = 1'b0;
      if (mode == 3) flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("hit_idle_no_wb", wb_valid_o, 1'b0);
      check("hit_idle_no_start", div_start_o, 1'b0);
    end else begin
      run_cycles = 0;
      done = 1'b0;
      step();
      while (!done) begin
        if (div_ready_i) begin
          if (mode == 2) begin
            flush_i = 1'b1;
            #1;
            check("ready_flush_start_low", div_start_o, 1'b0);
            step();
            flush_i = 1'b0;
            abort_tail();
          end else begin
            check("ready_start_low", div_start_o, 1'b0);
            exp_q.push_back('{waddr: wa, data: exp_v});
            step();
            check("miss_wb_valid", wb_valid_o, 1'b1);
            check("miss_wb_hold", hold_o, 1'b0);
            req_valid_i = 1'b0;
            if (mode == 3) flush_i = 1'b1;
            mc_valid = 1'b1; mc_op = op; mc_a = a; mc_b = b; mc_res = exp_v;
            step();
            flush_i = 1'b0;
            check("miss_idle_no_wb", wb_valid_o, 1'b0);
          end
          done = 1'b1;
        end else if (mode == 1 && run_cycles == flush_at) begin
          flush_i = 1'b1;
          #1;
          check("flush_start_low", div_start_o, 1'b0);
          step();
          flush_i = 1'b0;
          abort_tail();
          done = 1'b1;
        end else begin
          check("run_start_high", div_start_o, 1'b1);
          check("run_hold_high", hold_o, 1'b1);
          run_cycles++;
          if (run_cycles > 200) begin
            check("run_timeout", 1'b0, 1'b1);
            done = 1'b1;
          end else begin
            step();
          end
        end
      end
    end
  endtask

  task automatic idle_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid_i = 1'b1; req_op_i = op; req_dividend_i = a; req_divisor_i = b;
    req_waddr_i = 5'd1; flush_i = 1'b1;
    #1;
    check("idle_flush_hold", hold_o, 1'b0);
    step();
    req_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check("idle_flush_no_wb", wb_valid_o, 1'b0);
    check("idle_flush_no_start", div_start_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op, last_op;
    logic [31:0] a, b, last_a, last_b;
    int r, mode;
    rst = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_dividend_i = '0;
    req_divisor_i = '0; req_waddr_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold", hold_o, 1'b0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_waddr", wb_waddr_o, 5'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_div_start", div_start_o, 1'b0);
    check("rst_div_op", div_op_o, 3'd0);
    check("rst_div_dividend", div_dividend_o, 32'd0);
    check("rst_div_divisor", div_divisor_o, 32'd0);
    check("rst_div_waddr", div_waddr_o, 5'd0);

    check("model_div_100_7", ref_div(INST_DIV, 32'd100, 32'd7), 32'd14);
    check("model_rem_m7_2", ref_div(INST_REM, -32'sd7, 32'd2), 32'hFFFF_FFFF);
    check("model_divu_5_0", ref_div(INST_DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_div_1000_3", ref_div(INST_DIV, 32'd1000, 32'd3), 32'd333);
    check("model_divu_max_16", ref_div(INST_DIVU, 32'hFFFF_FFFF, 32'd16), 32'h0FFF_FFFF);
    check("model_remu_max_16", ref_div(INST_REMU, 32'hFFFF_FFFF, 32'd16), 32'h0000_000F);
    check("model_div_ovf", ref_div(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_rem_ovf", ref_div(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    step();

    do_req(INST_DIV, 32'd100, 32'd7, 5'd3, 0, 0);
    do_req(INST_REM, -32'sd7, 32'd2, 5'd5, 0, 0);
    do_req(INST_REM, -32'sd7, 32'd2, 5'd6, 0, 0);
    do_req(INST_DIVU, 32'd5, 32'd0, 5'd7, 0, 0);
    do_req(INST_DIV, 32'd1000, 32'd3, 5'd9, 1, 10);
    do_req(INST_DIVU, 32'd5, 32'd0, 5'd8, 3, 0);
    do_req(INST_DIV, 32'd1000, 32'd3, 5'd9, 0, 0);
    do_req(INST_DIV, 32'd77, 32'd5, 5'd10, 2, 0);
    do_req(INST_DIV, 32'd77, 32'd5, 5'd11, 3, 0);
    do_req(INST_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd12, 0, 0);
    do_req(INST_REMU, 32'hFFFF_FFFF, 32'd16, 5'd13, 0, 0);
    idle_flush(INST_REMU, 32'hFFFF_FFFF, 32'd16);
    do_req(INST_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd14, 0, 0);
    do_req(INST_REMU, 32'd9, 32'd0, 5'd15, 1, 0);

    last_op = INST_DIVU; last_a = 32'hFFFF_FFFF; last_b = 32'd16;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        op = last_op; a = last_a; b = last_b;
      end else begin
        op = 3'b100 | 3'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: a = 32'h8000_0000;
          1: a = $urandom_range(0, 1000);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: b = 32'd0;
          1: b = 32'hFFFF_FFFF;
          2: b = $urandom;
          default: b = $urandom_range(1, 20);
        endcase
      end
      r = $urandom_range(0, 19);
      mode = (r < 2) ? 1 : (r == 2) ? 2 : (r < 5) ? 3 : 0;
      if (r == 19) idle_flush(op, a, b);
      do_req(op, a, b, 5'($urandom), mode, $urandom_range(0, 12));
      last_op = op; last_a = a; last_b = b;
    end

    step();
    check("expected_wb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
